// File: rtl/fixed_point_accel_pkg.sv
// rtl/fixed_point_accel_pkg.sv - shared encodings for the fixed-point accelerator master and adapter
//
// Holds the master FSM state encoding, the accelerator word width and the
// ALU op-code values understood by the accelerator-side adapter.
package fixed_point_accel_pkg;

    localparam int ACCEL_WORD_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE_OP  = 3'd1,
        ST_WRITE_A   = 3'd2,
        ST_WRITE_B   = 3'd3,
        ST_READ_INT  = 3'd4,
        ST_READ_FRAC = 3'd5,
        ST_RESP      = 3'd6
    } state_t;

    // Op codes forwarded verbatim to the accelerator; the master never decodes them.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_DIV = 3'd3,
        ALU_AND = 3'd4,
        ALU_OR  = 3'd5,
        ALU_XOR = 3'd6,
        ALU_NEG = 3'd7
    } alu_op_t;

    function automatic logic is_write_state(state_t s);
        return (s == ST_WRITE_OP) || (s == ST_WRITE_A) || (s == ST_WRITE_B);
    endfunction

    function automatic logic is_read_state(state_t s);
        return (s == ST_READ_INT) || (s == ST_READ_FRAC);
    endfunction

endpackage

// File: rtl/fixed_point_accel_watchdog.sv
// rtl/fixed_point_accel_watchdog.sv - per-state stall watchdog for the accelerator master
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   active    - master is in a state that waits on the peer
//   restart   - master changes state on the coming edge; count starts over
//   expired   - the current state has waited TIMEOUT_CYCLES cycles (combinational)
module fixed_point_accel_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic restart,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!active || restart) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Count 0 is the first cycle in a state, so TIMEOUT_CYCLES-1 is the last allowed one.
    assign expired = active && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fixed_point_accel_master.sv
// rtl/fixed_point_accel_master.sv - request/response master driving a word-serial fixed-point accelerator
//
// Accepts {op, a, b}, writes them to the peer as three 16-bit words, reads back
// the integer and fractional fields, and presents the assembled result.
// Optional watchdog: define FIXED_POINT_ACCEL_MASTER_TIMEOUT_EN.
//
// Ports:
//   clk, rst                                - clock, asynchronous active-high reset
//   req_valid/req_ready, req_op/req_a/req_b - request handshake and operands
//   resp_valid/resp_ready, resp_result      - response handshake and result
//   resp_error                              - response produced by the watchdog
//   accel_can_write/accel_write_enable/accel_write_data - word stream to the peer
//   accel_can_read/accel_read_enable/accel_read_data    - word stream from the peer
module fixed_point_accel_master
    import fixed_point_accel_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int TIMEOUT_CYCLES        = 1024,
    localparam int NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_op,
    input  logic [NUMBER_WIDTH-1:0]     req_a,
    input  logic [NUMBER_WIDTH-1:0]     req_b,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [NUMBER_WIDTH-1:0]     resp_result,
    output logic                        resp_error,
    input  logic                        accel_can_read,
    input  logic                        accel_can_write,
    output logic                        accel_read_enable,
    output logic                        accel_write_enable,
    input  logic [ACCEL_WORD_WIDTH-1:0] accel_read_data,
    output logic [ACCEL_WORD_WIDTH-1:0] accel_write_data
);

    state_t                           state, next_state;
    logic [2:0]                       op_q;
    logic [NUMBER_WIDTH-1:0]          a_q, b_q;
    logic [INTEGER_PART_WIDTH-1:0]    int_q;
    logic [FRACTIONAL_PART_WIDTH-1:0] frac_q;
    logic                             err_q;
    logic                             timeout;

    // Only the low field bits of each returned word carry data.
    logic unused_read_bits;
    assign unused_read_bits = ^accel_read_data;

`ifdef FIXED_POINT_ACCEL_MASTER_TIMEOUT_EN
    logic wd_active;
    assign wd_active = (state != ST_IDLE) && (state != ST_RESP);

    fixed_point_accel_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (wd_active),
        .restart (state != next_state),
        .expired (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (state == ST_RESP && resp_ready) begin
            err_q <= 1'b0;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a watchdog expiry overrides any transfer in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (req_valid)       next_state = ST_WRITE_OP;
            ST_WRITE_OP:  if (accel_can_write) next_state = ST_WRITE_A;
            ST_WRITE_A:   if (accel_can_write) next_state = ST_WRITE_B;
            ST_WRITE_B:   if (accel_can_write) next_state = ST_READ_INT;
            ST_READ_INT:  if (accel_can_read)  next_state = ST_READ_FRAC;
            ST_READ_FRAC: if (accel_can_read)  next_state = ST_RESP;
            ST_RESP:      if (resp_ready)      next_state = ST_IDLE;
            default:                           next_state = ST_IDLE;
        endcase
        if (timeout) begin
            next_state = ST_RESP;
        end
    end

    // Output logic
    always_comb begin
        req_ready          = (state == ST_IDLE);
        resp_valid         = (state == ST_RESP);
        resp_result        = {int_q, frac_q};
        resp_error         = err_q;
        accel_write_enable = is_write_state(state) && accel_can_write;
        accel_read_enable  = is_read_state(state) && accel_can_read;
        case (state)
            ST_WRITE_OP: accel_write_data = ACCEL_WORD_WIDTH'(op_q);
            ST_WRITE_A:  accel_write_data = ACCEL_WORD_WIDTH'(a_q);
            ST_WRITE_B:  accel_write_data = ACCEL_WORD_WIDTH'(b_q);
            default:     accel_write_data = '0;
        endcase
    end

    // Request capture and result assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            int_q  <= '0;
            frac_q <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (timeout) begin
                int_q  <= '0;
                frac_q <= '0;
            end else if (state == ST_READ_INT && accel_can_read) begin
                int_q <= accel_read_data[INTEGER_PART_WIDTH-1:0];
            end else if (state == ST_READ_FRAC && accel_can_read) begin
                frac_q <= accel_read_data[FRACTIONAL_PART_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_accel_master.sv
// tb/tb_fixed_point_accel_master.sv - scoreboard bench for fixed_point_accel_master
module tb_fixed_point_accel_master;

    localparam int IW = 8;
    localparam int FW = 8;
    localparam int NW = IW + FW;
    localparam int TO = 16;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [NW-1:0] req_a, req_b;
    logic          resp_valid;
    logic          resp_ready;
    logic [NW-1:0] resp_result;
    logic          resp_error;
    logic          accel_can_read, accel_can_write;
    logic          accel_read_enable, accel_write_enable;
    logic [15:0]   accel_read_data, accel_write_data;

    fixed_point_accel_master #(
        .INTEGER_PART_WIDTH   (IW),
        .FRACTIONAL_PART_WIDTH(FW),
        .TIMEOUT_CYCLES       (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_a             (req_a),
        .req_b             (req_b),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_result       (resp_result),
        .resp_error        (resp_error),
        .accel_can_read    (accel_can_read),
        .accel_can_write   (accel_can_write),
        .accel_read_enable (accel_read_enable),
        .accel_write_enable(accel_write_enable),
        .accel_read_data   (accel_read_data),
        .accel_write_data  (accel_write_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [NW-1:0] result;
        logic          error;
        int            lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] wexp_q[$];
    logic [15:0] rd_q[$];
    int          acc_q[$];

    int errors = 0;
    int checks = 0;
    int sidx = 0;
    int resp_done = 0;
    bit rand_mode = 1'b0;
    logic cw_man = 1'b1;
    logic cr_man = 1'b1;
    logic rr_man = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result = low IW bits of the first word, then low FW bits of the second.
    function automatic logic [NW-1:0] model(input logic [15:0] wi, input logic [15:0] wf);
        int iv, fv;
        iv = int'(wi) % (1 << IW);
        fv = int'(wf) % (1 << FW);
        return NW'(iv * (1 << FW) + fv);
    endfunction

    // Samples 1ns before each rising edge; also plays the peer's data source.
    task automatic monitor();
        bit            in_resp;
        bit            pop;
        logic [NW-1:0] held_r;
        logic          held_e;
        exp_t          e;
        int            acc;
        in_resp = 1'b0;
        held_r  = '0;
        held_e  = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            sidx++;
            pop = 1'b0;
            if (rst) begin
                in_resp = 1'b0;
            end else begin
                check("one_strobe", 32'(accel_read_enable & accel_write_enable), 0);
                check("wr_strobe_gated", 32'(accel_write_enable & ~accel_can_write), 0);
                check("rd_strobe_gated", 32'(accel_read_enable & ~accel_can_read), 0);
                if (req_valid && req_ready) acc_q.push_back(sidx);
                if (accel_write_enable) begin
                    if (wexp_q.size() == 0) check("wr_unexpected", 1, 0);
                    else check("wr_word", 32'(accel_write_data), 32'(wexp_q.pop_front()));
                end
                if (accel_read_enable) pop = 1'b1;
                if (resp_valid) begin
                    check("busy_not_ready", 32'(req_ready), 0);
                    if (!in_resp) begin
                        in_resp = 1'b1;
                        held_r  = resp_result;
                        held_e  = resp_error;
                        if (exp_q.size() == 0 || acc_q.size() == 0) begin
                            check("resp_unexpected", 1, 0);
                        end else begin
                            e   = exp_q.pop_front();
                            acc = acc_q.pop_front();
                            check("result", 32'(resp_result), 32'(e.result));
                            check("error", 32'(resp_error), 32'(e.error));
                            if (e.lat >= 0) check("latency", 32'(sidx - acc), 32'(e.lat));
                        end
                    end else begin
                        check("result_stable", 32'(resp_result), 32'(held_r));
                        check("error_stable", 32'(resp_error), 32'(held_e));
                    end
                    if (resp_ready) begin
                        in_resp = 1'b0;
                        resp_done++;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (pop && rd_q.size() > 0) void'(rd_q.pop_front());
            accel_read_data = (rd_q.size() > 0) ? rd_q[0] : 16'hDEAD;
        end
    endtask

    task automatic peer();
        forever begin
            @(negedge clk);
            #1;
            if (rand_mode) begin
                accel_can_write = ($urandom_range(0, 3) != 0);
                accel_can_read  = ($urandom_range(0, 3) != 0);
                resp_ready      = ($urandom_range(0, 2) != 0);
            end else begin
                accel_can_write = cw_man;
                accel_can_read  = cr_man;
                resp_ready      = rr_man;
            end
        end
    endtask

    // Pushes the expectation, then presents the request until it is accepted.
    task automatic issue(input logic [2:0] op, input logic [NW-1:0] a, input logic [NW-1:0] b,
                         input logic [15:0] wi, input logic [15:0] wf, input int lat, input bit to_case);
        exp_t e;
        int   n;
        if (to_case) begin
            e.result = '0;
            e.error  = 1'b1;
        end else begin
            e.result = model(wi, wf);
            e.error  = 1'b0;
            rd_q.push_back(wi);
            rd_q.push_back(wf);
        end
        e.lat = lat;
        exp_q.push_back(e);
        wexp_q.push_back(16'(op));
        wexp_q.push_back(16'(a));
        wexp_q.push_back(16'(b));
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        n = 0;
        forever begin
            #2;
            if (req_ready) break;
            @(negedge clk);
            n++;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = NW'($urandom);
        req_b     = NW'($urandom);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (resp_done < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("resp_arrived", 32'(resp_done >= target), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 0);
        check({tag, "_strobes"}, 32'({accel_read_enable, accel_write_enable}), 0);
        check({tag, "_wdata"}, 32'(accel_write_data), 0);
    endtask

    initial begin
        int done;
        int n;
        rst             = 1'b1;
        req_valid       = 1'b0;
        req_op          = '0;
        req_a           = '0;
        req_b           = '0;
        resp_ready      = 1'b1;
        accel_can_read  = 1'b1;
        accel_can_write = 1'b1;
        accel_read_data = 16'hDEAD;
        fork
            monitor();
            peer();
        join_none

        repeat (3) @(negedge clk);
        #3;
        check_idle_outputs("reset");
        check("reset_result", 32'(resp_result), 0);
        check("reset_error", 32'(resp_error), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic transaction, peer always ready
        issue(3'd1, 16'h0180, 16'h0240, 16'h0003, 16'h00C0, 6, 1'b0);
        done = 1;
        wait_done(done);

        // Upper bits of returned words are dropped
        issue(3'd2, NW'($urandom), NW'($urandom), 16'hFF12, 16'hAB34, 6, 1'b0);
        done++;
        wait_done(done);

        // Write stall of 5 cycles in WRITE_A
        issue(3'd5, 16'h1357, 16'h2468, 16'h0042, 16'h0081, 11, 1'b0);
        @(negedge clk);
        cw_man = 1'b0;
        repeat (5) @(negedge clk);
        cw_man = 1'b1;
        done++;
        wait_done(done);

        // Response held off for 10 cycles while a second request is offered
        rr_man = 1'b0;
        issue(3'd3, 16'hBEEF, 16'h0F0F, 16'h0077, 16'h0099, 6, 1'b0);
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("held_resp_seen", 32'(resp_valid), 1);
        repeat (10) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = 3'd7;
            req_a     = NW'($urandom);
            req_b     = NW'($urandom);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rr_man    = 1'b1;
        done++;
        wait_done(done);

        // Reset in WRITE_B abandons the transaction
        issue(3'd4, 16'h1111, 16'h2222, 16'h0033, 16'h0044, 6, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #3;
        check_idle_outputs("midrst");
        exp_q.delete();
        wexp_q.delete();
        rd_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(3'd6, 16'h5A5A, 16'hA5A5, 16'h0012, 16'h0034, 6, 1'b0);
        done++;
        wait_done(done);

        // Randomized traffic and handshakes
        rand_mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            issue(3'($urandom), NW'($urandom), NW'($urandom), 16'($urandom), 16'($urandom), -1, 1'b0);
            done++;
            wait_done(done);
        end
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);

`ifdef FIXED_POINT_ACCEL_MASTER_TIMEOUT_EN
        // Peer never supplies a word: watchdog fires after TO stalled cycles
        cr_man = 1'b0;
        issue(3'd1, 16'h0A0A, 16'h0B0B, 16'h0000, 16'h0000, 3 + TO + 1, 1'b1);
        done++;
        wait_done(done);
        @(negedge clk);
        cr_man = 1'b1;
        issue(3'd2, 16'h0C0C, 16'h0D0D, 16'h0055, 16'h0066, 6, 1'b0);
        done++;
        wait_done(done);
`endif

        repeat (3) @(negedge clk);
        check("queues_drained", 32'(exp_q.size() + wexp_q.size() + rd_q.size() + acc_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
